// File: rtl/qupls4_pkg.sv
// Shared types and defaults for the Qupls4 memory-issue scheduler.
// Address bits below LINE_LSB select a byte within a 16-byte line and are ignored for overlap checks.
package qupls4_pkg;
  localparam int LSQ_ROWS_DEF         = 8;
  localparam int LSQ_COLS_DEF         = 2;
  localparam int NDATA_PORTS          = 2;
  localparam int MAX_STORES_PER_CYCLE = 1;
  localparam int PAW_DEF              = 32;
  localparam int MEM_ISS_IW           = $clog2(LSQ_ROWS_DEF * LSQ_COLS_DEF);
  localparam int LINE_LSB             = 4;

  typedef logic [MEM_ISS_IW-1:0]  mem_iss_ndx_t;
  typedef logic [NDATA_PORTS-1:0] mem_port_mask_t;
endpackage

// File: rtl/qupls4_mem_age_pick.sv
// Combinational age-ordered picker: walks ready entries oldest first from the head row and
// hands each one to the lowest free port it may use, skipping entries that find no port.
module qupls4_mem_age_pick
  import qupls4_pkg::*;
#(
  parameter  int ROWS  = LSQ_ROWS_DEF,
  parameter  int COLS  = LSQ_COLS_DEF,
  parameter  int NP    = NDATA_PORTS,
  parameter  int MAXST = MAX_STORES_PER_CYCLE,
  localparam int N     = ROWS * COLS,
  localparam int IW    = $clog2(N),
  localparam int RW    = $clog2(ROWS)
) (
  input  logic [N-1:0]     i_rdy,
  input  logic [RW-1:0]    i_head,
  input  logic [NP-1:0]    i_free,
  input  logic [N-1:0]     i_port0,
  input  logic [N-1:0]     i_store,
  output logic [NP-1:0]    o_pv,
  output logic [NP*IW-1:0] o_pndx,
  output logic [N-1:0]     o_sel
);

  always_comb begin
    logic [RW-1:0] v_row;
    logic [IW-1:0] v_idx;
    logic          v_got;
    int            v_nst;
    o_pv   = '0;
    o_pndx = '0;
    o_sel  = '0;
    v_row  = '0;
    v_idx  = '0;
    v_got  = 1'b0;
    v_nst  = 0;
    for (int p = 0; p < N; p++) begin
      // Row arithmetic wraps naturally because ROWS is a power of two.
      v_row = i_head + RW'(p / COLS);
      v_idx = IW'(int'(v_row) * COLS + p % COLS);
      v_got = 1'b0;
      if (i_rdy[v_idx] && !(i_store[v_idx] && v_nst >= MAXST)) begin
        for (int k = 0; k < NP; k++) begin
          if (!v_got && i_free[k] && !o_pv[k] && (k == 0 || !i_port0[v_idx])) begin
            v_got               = 1'b1;
            o_pv[k]             = 1'b1;
            o_pndx[k*IW +: IW]  = v_idx;
            o_sel[v_idx]        = 1'b1;
          end
        end
        if (v_got && i_store[v_idx]) v_nst = v_nst + 1;
      end
    end
  end

endmodule

// File: rtl/qupls4_mem_issue_sched.sv
// Memory-issue scheduler: picks up to NPORTS ready LSQ ops per cycle onto registered port channels
// (one cycle latency); a stalled port holds its op unless the op is stomped or replayed.
module qupls4_mem_issue_sched
  import qupls4_pkg::*;
#(
  parameter  int LSQ_ROWS   = LSQ_ROWS_DEF,
  parameter  int LSQ_COLS   = LSQ_COLS_DEF,
  parameter  int NPORTS     = NDATA_PORTS,
  parameter  int MAX_STORES = MAX_STORES_PER_CYCLE,
  parameter  int PAW        = PAW_DEF,
  localparam int N          = LSQ_ROWS * LSQ_COLS,
  localparam int IW         = $clog2(N),
  localparam int RW         = $clog2(LSQ_ROWS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [RW-1:0]        lsq_head_row,
  input  logic [N-1:0]         ent_v,
  input  logic [N-1:0]         ent_agen,
  input  logic [N-1:0]         ent_load,
  input  logic [N-1:0]         ent_store,
  input  logic [N-1:0]         ent_datav,
  input  logic [N-1:0]         ent_port0,
  input  logic [N-1:0]         ent_store_safe,
  input  logic [N-1:0]         ent_done,
  input  logic [N-1:0]         ent_stomp,
  input  logic [N*PAW-1:0]     ent_padr,
  input  logic [N-1:0]         replay,
  input  logic                 fence,
  input  logic                 seq_mode,
  input  logic [NPORTS-1:0]    port_rdy,
  output logic [NPORTS-1:0]    port_v,
  output logic [NPORTS*IW-1:0] port_ndx,
  output logic [N-1:0]         inflight
);

  logic [NPORTS-1:0]    r_port_v;
  logic [NPORTS*IW-1:0] r_port_ndx;
  logic [N-1:0]         r_inflight;

  logic [IW-1:0]        w_pos [N];
  logic [N-1:0]         w_ovl;
  logic [N-1:0]         w_base;
  logic [N-1:0]         w_ord_ok;
  logic [N-1:0]         w_rdy;
  logic [N-1:0]         w_sel;
  logic [NPORTS-1:0]    w_free;
  logic [NPORTS-1:0]    w_pick_v;
  logic [NPORTS*IW-1:0] w_pick_ndx;
  logic [NPORTS-1:0]    w_port_v_nxt;
  logic [NPORTS*IW-1:0] w_port_ndx_nxt;
  logic [N-1:0]         w_inflight_nxt;
  logic                 w_unused_padr;

  // Age position relative to the head row, so ordering survives head wrap.
  always_comb begin
    for (int i = 0; i < N; i++)
      w_pos[i] = IW'(int'(RW'(i / LSQ_COLS) - lsq_head_row) * LSQ_COLS + i % LSQ_COLS);
  end

  always_comb begin
    w_ovl = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (w_pos[j] < w_pos[i] && ent_v[j] && !ent_done[j] &&
            (!ent_agen[j] ||
             ent_padr[j*PAW+LINE_LSB +: PAW-LINE_LSB] == ent_padr[i*PAW+LINE_LSB +: PAW-LINE_LSB]) &&
            !(ent_load[i] && ent_load[j]))
          w_ovl[i] = 1'b1;
  end

  assign w_base = ent_v & ent_agen & (ent_load | ent_datav) & ~r_inflight & ~ent_stomp &
                  ~ent_done & {N{~fence}} & (~ent_store | ent_store_safe) & ~w_ovl;

  // Relaxed mode lets an older entry that is itself issuable (or stomped) stand aside.
  always_comb begin
    w_ord_ok = '1;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (w_pos[j] < w_pos[i] && ent_v[j] && !ent_done[j] &&
            (seq_mode || !(r_inflight[j] || w_base[j] || ent_stomp[j])))
          w_ord_ok[i] = 1'b0;
  end

  assign w_rdy  = w_base & w_ord_ok;
  assign w_free = ~r_port_v | port_rdy;

  qupls4_mem_age_pick #(
    .ROWS  (LSQ_ROWS),
    .COLS  (LSQ_COLS),
    .NP    (NPORTS),
    .MAXST (MAX_STORES)
  ) u_pick (
    .i_rdy   (w_rdy),
    .i_head  (lsq_head_row),
    .i_free  (w_free),
    .i_port0 (ent_port0),
    .i_store (ent_store),
    .o_pv    (w_pick_v),
    .o_pndx  (w_pick_ndx),
    .o_sel   (w_sel)
  );

  always_comb begin
    logic [IW-1:0] v_ndx;
    w_port_v_nxt   = '0;
    w_port_ndx_nxt = r_port_ndx;
    v_ndx          = '0;
    for (int k = 0; k < NPORTS; k++) begin
      v_ndx = r_port_ndx[k*IW +: IW];
      if (!w_free[k]) begin
        w_port_v_nxt[k] = !(ent_stomp[v_ndx] || replay[v_ndx]);
      end else if (w_pick_v[k]) begin
        w_port_v_nxt[k]              = 1'b1;
        w_port_ndx_nxt[k*IW +: IW]   = w_pick_ndx[k*IW +: IW];
      end
    end
  end

  assign w_inflight_nxt = (r_inflight & ent_v & ~replay & ~ent_done & ~ent_stomp) | w_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_port_v   <= '0;
      r_port_ndx <= '0;
      r_inflight <= '0;
    end else begin
      r_port_v   <= w_port_v_nxt;
      r_port_ndx <= w_port_ndx_nxt;
      r_inflight <= w_inflight_nxt;
    end
  end

  assign w_unused_padr = ^ent_padr;

  assign port_v   = r_port_v;
  assign port_ndx = r_port_ndx;
  assign inflight = r_inflight;

endmodule

// File: tb/tb_qupls4_mem_issue_sched.sv
// Directed and randomized checks of the memory-issue scheduler against a queue-based age-order model.
module tb_qupls4_mem_issue_sched;
  import qupls4_pkg::*;

  localparam int ROWS  = 8;
  localparam int COLS  = 2;
  localparam int NP    = 2;
  localparam int MAXST = 1;
  localparam int PAW   = 32;
  localparam int N     = ROWS * COLS;
  localparam int IW    = $clog2(N);
  localparam int RW    = $clog2(ROWS);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [RW-1:0]     lsq_head_row;
  logic [N-1:0]      ent_v, ent_agen, ent_load, ent_store, ent_datav, ent_port0;
  logic [N-1:0]      ent_store_safe, ent_done, ent_stomp, replay;
  logic [N*PAW-1:0]  ent_padr;
  logic              fence, seq_mode;
  logic [NP-1:0]     port_rdy;
  logic [NP-1:0]     port_v;
  logic [NP*IW-1:0]  port_ndx;
  logic [N-1:0]      inflight;

  int checks = 0;
  int errors = 0;

  mem_port_mask_t m_v, n_v;
  int             m_ndx [NP];
  int             n_ndx [NP];
  logic [N-1:0]   m_inf, n_inf;

  always #5 clk = ~clk;

  qupls4_mem_issue_sched #(
    .LSQ_ROWS(ROWS), .LSQ_COLS(COLS), .NPORTS(NP), .MAX_STORES(MAXST), .PAW(PAW)
  ) dut (
    .clk(clk), .rst(rst), .lsq_head_row(lsq_head_row),
    .ent_v(ent_v), .ent_agen(ent_agen), .ent_load(ent_load), .ent_store(ent_store),
    .ent_datav(ent_datav), .ent_port0(ent_port0), .ent_store_safe(ent_store_safe),
    .ent_done(ent_done), .ent_stomp(ent_stomp), .ent_padr(ent_padr), .replay(replay),
    .fence(fence), .seq_mode(seq_mode), .port_rdy(port_rdy),
    .port_v(port_v), .port_ndx(port_ndx), .inflight(inflight)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PAW-5:0] line_of(input int i);
    return ent_padr[i*PAW+4 +: PAW-4];
  endfunction

  // Reference: list entries by age, apply the readiness rules, hand out ports oldest first.
  task automatic model_next();
    int         order[$];
    int         age[N];
    bit         base[N];
    bit         rdy[N];
    bit         taken[NP];
    logic [N-1:0] sel;
    int         nst;
    sel = '0;
    nst = 0;
    for (int p = 0; p < N; p++) begin
      int ix;
      ix = ((int'(lsq_head_row) + p / COLS) % ROWS) * COLS + p % COLS;
      order.push_back(ix);
      age[ix] = p;
    end
    for (int i = 0; i < N; i++) begin
      bit ovl;
      ovl = 0;
      for (int j = 0; j < N; j++)
        if (age[j] < age[i] && ent_v[j] && !ent_done[j] &&
            (!ent_agen[j] || line_of(j) == line_of(i)) && !(ent_load[i] && ent_load[j]))
          ovl = 1;
      base[i] = ent_v[i] && ent_agen[i] && (ent_load[i] || ent_datav[i]) && !m_inf[i] &&
                !ent_stomp[i] && !ent_done[i] && !fence && (!ent_store[i] || ent_store_safe[i]) && !ovl;
    end
    for (int i = 0; i < N; i++) begin
      bit ok;
      ok = 1;
      for (int j = 0; j < N; j++)
        if (age[j] < age[i] && ent_v[j]) begin
          if (seq_mode) begin
            if (!ent_done[j]) ok = 0;
          end else begin
            if (!(ent_done[j] || m_inf[j] || base[j] || ent_stomp[j])) ok = 0;
          end
        end
      rdy[i] = base[i] && ok;
    end
    for (int k = 0; k < NP; k++) begin
      n_ndx[k] = m_ndx[k];
      taken[k] = 0;
      n_v[k]   = 1'b0;
      if (m_v[k] && !port_rdy[k]) begin
        taken[k] = 1;
        n_v[k]   = !(ent_stomp[m_ndx[k]] || replay[m_ndx[k]]);
      end
    end
    foreach (order[p]) begin
      int ix;
      int got;
      ix  = order[p];
      got = -1;
      if (rdy[ix] && !(ent_store[ix] && nst >= MAXST)) begin
        for (int k = 0; k < NP; k++)
          if (got < 0 && !taken[k] && (k == 0 || !ent_port0[ix])) got = k;
        if (got >= 0) begin
          taken[got] = 1;
          n_v[got]   = 1'b1;
          n_ndx[got] = ix;
          sel[ix]    = 1'b1;
          if (ent_store[ix]) nst++;
        end
      end
    end
    for (int i = 0; i < N; i++)
      n_inf[i] = (m_inf[i] && ent_v[i] && !replay[i] && !ent_done[i] && !ent_stomp[i]) || sel[i];
  endtask

  task automatic step();
    model_next();
    @(posedge clk);
    #1;
    m_v   = n_v;
    m_inf = n_inf;
    for (int k = 0; k < NP; k++) m_ndx[k] = n_ndx[k];
    chk("port_v", port_v, m_v);
    chk("inflight", inflight, m_inf);
    for (int k = 0; k < NP; k++)
      if (m_v[k]) chk("port_ndx", port_ndx[k*IW +: IW], m_ndx[k]);
  endtask

  task automatic clear_inputs();
    lsq_head_row = '0;
    ent_v = '0; ent_agen = '0; ent_load = '0; ent_store = '0; ent_datav = '0;
    ent_port0 = '0; ent_store_safe = '0; ent_done = '0; ent_stomp = '0; replay = '0;
    ent_padr = '0; fence = 1'b0; seq_mode = 1'b0; port_rdy = '1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_port_v", port_v, 0);
    chk("rst_port_ndx", port_ndx, 0);
    chk("rst_inflight", inflight, 0);
    rst   = 1'b0;
    m_v   = '0;
    m_inf = '0;
    for (int k = 0; k < NP; k++) m_ndx[k] = 0;
  endtask

  task automatic put(input int i, input bit is_st, input int line, input bit p0);
    ent_v[i] = 1'b1; ent_agen[i] = 1'b1; ent_load[i] = !is_st; ent_store[i] = is_st;
    ent_datav[i] = is_st; ent_store_safe[i] = 1'b1; ent_port0[i] = p0;
    ent_padr[i*PAW +: PAW] = PAW'(line) << 4;
  endtask

  task automatic rand_inputs();
    if ($urandom_range(7) == 0) lsq_head_row = RW'($urandom_range(ROWS-1));
    fence = ($urandom_range(15) == 0);
    if ($urandom_range(31) == 0) seq_mode = !seq_mode;
    for (int k = 0; k < NP; k++) port_rdy[k] = ($urandom_range(3) != 0);
    for (int i = 0; i < N; i++) begin
      if ($urandom_range(3) == 0) begin
        bit st;
        st = ($urandom_range(1) == 1);
        ent_v[i]          = ($urandom_range(3) != 0);
        ent_agen[i]       = ($urandom_range(3) != 0);
        ent_load[i]       = !st;
        ent_store[i]      = st;
        ent_datav[i]      = ($urandom_range(1) == 1);
        ent_port0[i]      = ($urandom_range(3) == 0);
        ent_store_safe[i] = ($urandom_range(3) != 0);
        ent_padr[i*PAW +: PAW] = (PAW'($urandom_range(3)) << 4) | PAW'($urandom_range(15));
      end
      ent_done[i]  = ($urandom_range(9) == 0);
      ent_stomp[i] = ($urandom_range(15) == 0);
      replay[i]    = m_inf[i] && ($urandom_range(7) == 0);
    end
  endtask

  initial begin
    clear_inputs();
    #2;
    chk("arst_init_port_v", port_v, 0);

    // Two loads to distinct lines issue together.
    do_reset();
    put(0, 0, 1, 0); put(3, 0, 2, 0);
    step();
    chk("t1_port_v", port_v, 2'b11);
    chk("t1_port_ndx", port_ndx, 8'h30);
    chk("t1_inflight", inflight, 16'h0009);

    // Store cap: one store per cycle.
    do_reset();
    put(1, 1, 1, 0); put(2, 1, 2, 0);
    step();
    chk("t2a_port_v", port_v, 2'b01);
    chk("t2a_ndx0", port_ndx[3:0], 1);
    step();
    chk("t2b_ndx0", port_ndx[3:0], 2);
    chk("t2b_inflight", inflight, 16'h0006);

    // Head wrap ordering.
    do_reset();
    lsq_head_row = 3'd7;
    put(14, 0, 1, 0); put(0, 0, 2, 0);
    step();
    chk("t3_port_v", port_v, 2'b11);
    chk("t3_port_ndx", port_ndx, 8'h0E);
    chk("t3_inflight", inflight, 16'h4001);

    // Same-line store blocks younger load until done.
    do_reset();
    put(2, 1, 5, 0); put(4, 0, 5, 0);
    step();
    chk("t4a_port_v", port_v, 2'b01);
    chk("t4a_ndx0", port_ndx[3:0], 2);
    step();
    chk("t4b_port_v", port_v, 2'b00);
    ent_done[2] = 1'b1;
    step();
    chk("t4c_port_v", port_v, 2'b01);
    chk("t4c_ndx0", port_ndx[3:0], 4);
    chk("t4c_inflight", inflight, 16'h0010);

    // Replay of a stalled op.
    do_reset();
    put(5, 0, 3, 0);
    port_rdy = 2'b10;
    step();
    step();
    chk("t5a_port_v", port_v, 2'b01);
    chk("t5a_ndx0", port_ndx[3:0], 5);
    replay[5] = 1'b1;
    step();
    chk("t5b_port_v", port_v, 2'b00);
    chk("t5b_inflight", inflight, 16'h0000);
    replay[5] = 1'b0;
    step();
    chk("t5c_port_v", port_v, 2'b01);
    chk("t5c_ndx0", port_ndx[3:0], 5);

    // Sequential mode, then fence.
    do_reset();
    seq_mode = 1'b1;
    put(0, 0, 1, 0); put(1, 0, 2, 0); put(2, 0, 3, 0);
    step();
    chk("t6a_port_v", port_v, 2'b01);
    chk("t6a_ndx0", port_ndx[3:0], 0);
    step();
    chk("t6b_port_v", port_v, 2'b00);
    ent_done[0] = 1'b1;
    step();
    chk("t6c_port_v", port_v, 2'b01);
    chk("t6c_ndx0", port_ndx[3:0], 1);
    ent_done[1] = 1'b1;
    fence = 1'b1;
    step();
    chk("t6d_port_v", port_v, 2'b00);
    fence = 1'b0;
    step();
    chk("t6e_ndx0", port_ndx[3:0], 2);

    // Port-0-only ops serialise on port 0.
    do_reset();
    put(0, 0, 1, 1); put(1, 0, 2, 1);
    step();
    chk("t7a_port_v", port_v, 2'b01);
    chk("t7a_ndx0", port_ndx[3:0], 0);
    step();
    chk("t7b_port_v", port_v, 2'b01);
    chk("t7b_ndx0", port_ndx[3:0], 1);

    // Asynchronous reset while a port is stalled.
    do_reset();
    put(5, 0, 3, 0);
    port_rdy = 2'b10;
    step();
    step();
    rst = 1'b1;
    #1;
    chk("arst_stall_port_v", port_v, 0);
    chk("arst_stall_inflight", inflight, 0);

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rand_inputs();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
